load_store_unit: RTL and testbench

//   Byte/halfword/word load-store engine between the execute stage and the word-wide data memory.

---
 rtl/load_store_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Byte/halfword/word load-store engine between the execute stage and a
//   word-wide data memory that has no byte enables. Sub-word stores therefore
//   run as read-modify-write: read the old word, merge the new lane, write back.
//   Loads are sign/zero-extended according to the RV32I funct3 encoding.
//   One request is in flight at a time; the sequencing is a small FSM
//   (IDLE, READ, WRITE, DONE).
//
//   Optional feature macro: MISALIGN_TRAP_EN
//     defined   : misaligned H/W accesses skip memory, finish in one cycle with
//                 misalign_o=1 and rdata_o=0.
//     undefined : misalign_o stays 0; low address bits are ignored per lane rules.
//
// Ports
//   clk_i       in   clock, rising edge
//   rst_i       in   synchronous active-high reset
//   req_i       in   request, accepted only in IDLE
//   we_i        in   1 = store, 0 = load
//   funct3_i    in   000 B, 001 H, 010 W, 100 BU, 101 HU (others invalid)
//   addr_i      in   byte address
//   wdata_i     in   store data (low bits used for B/H)
//   busy_o      out  FSM not in IDLE
//   done_o      out  one-cycle completion pulse
//   rdata_o     out  extended load result, held until next load completion
//   misalign_o  out  misalignment flag, valid with done_o
//   mem_we_o    out  memory write enable
//   mem_addr_o  out  word-aligned memory address
//   mem_data_o  out  memory write data
//   mem_data_i  in   memory read data, combinational from mem_addr_o
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [2:0]            funct3_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  misalign_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i
);

  localparam int NUM_LANES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_we;
  logic                  r_write_en;   // store with a valid funct3
  logic [2:0]            r_funct3;
  logic [1:0]            r_offset;     // byte offset inside the word
  logic [15:0]           r_wdata;      // only B/H data is needed after accept
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_data;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_misalign;

  // Decode of the incoming request (used at accept time). Stores take the
  // lane size from funct3[1:0]; bit 2 only matters for load extension.
  logic w_in_byte;
  logic w_in_half;
  logic w_in_word;
  logic w_in_valid;
  logic w_trap;

  assign w_in_byte  = (funct3_i[1:0] == 2'b00);
  assign w_in_half  = (funct3_i[1:0] == 2'b01);
  assign w_in_word  = (funct3_i == 3'b010);
  assign w_in_valid = w_in_byte | w_in_half | w_in_word;

`ifdef MISALIGN_TRAP_EN
  assign w_trap = (w_in_half & addr_i[0]) | (w_in_word & (addr_i[1:0] != 2'b00));
`else
  assign w_trap = 1'b0;
`endif

  // Decode of the latched request.
  logic w_byte;
  logic w_half;
  logic w_word;
  logic w_unsigned;

  assign w_byte     = (r_funct3[1:0] == 2'b00);
  assign w_half     = (r_funct3[1:0] == 2'b01);
  assign w_word     = (r_funct3 == 3'b010);
  assign w_unsigned = r_funct3[2];

  // Load lane extraction and extension from the word currently on mem_data_i.
  logic [7:0]            w_lane_byte;
  logic [15:0]           w_lane_half;
  logic [DATA_WIDTH-1:0] w_load_ext;

  assign w_lane_byte = mem_data_i[8*r_offset +: 8];
  assign w_lane_half = r_offset[1] ? mem_data_i[31:16] : mem_data_i[15:0];

  always_comb begin
    w_load_ext = '0;
    if (w_byte) begin
      w_load_ext = w_unsigned ? {{(DATA_WIDTH-8){1'b0}}, w_lane_byte}
                              : {{(DATA_WIDTH-8){w_lane_byte[7]}}, w_lane_byte};
    end else if (w_half) begin
      w_load_ext = w_unsigned ? {{(DATA_WIDTH-16){1'b0}}, w_lane_half}
                              : {{(DATA_WIDTH-16){w_lane_half[15]}}, w_lane_half};
    end else if (w_word) begin
      w_load_ext = mem_data_i;
    end
  end

  // Store merge: replace only the addressed lane(s) of the old word.
  // A halfword covers the lane pair selected by offset[1]; the upper byte of
  // the pair takes wdata[15:8].
  logic [DATA_WIDTH-1:0] w_merged;
  logic [NUM_LANES-1:0]  w_lane_hit;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      localparam logic [1:0] LANE_IDX = 2'(gi);
      logic [7:0] w_lane_data;

      assign w_lane_hit[gi] = (w_byte & (r_offset == LANE_IDX)) |
                              (w_half & (r_offset[1] == LANE_IDX[1]));
      assign w_lane_data    = (w_half & LANE_IDX[0]) ? r_wdata[15:8] : r_wdata[7:0];
      assign w_merged[8*gi +: 8] = w_lane_hit[gi] ? w_lane_data : mem_data_i[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_write_en <= 1'b0;
      r_funct3   <= 3'b000;
      r_offset   <= 2'b00;
      r_wdata    <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_rdata    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_i) begin
            r_we       <= we_i;
            r_write_en <= we_i & w_in_valid;
            r_funct3   <= funct3_i;
            r_offset   <= addr_i[1:0];
            r_wdata    <= wdata_i[15:0];
            r_mem_addr <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
            r_busy     <= 1'b1;
            if (w_trap) begin
              // Misaligned access: no memory cycle, report immediately.
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_misalign <= 1'b1;
              r_rdata    <= '0;
            end else if (we_i & (w_in_word | !w_in_valid)) begin
              // Full-word stores (and invalid stores, which keep the normal
              // store latency but never raise mem_we_o) skip the read.
              r_state    <= S_WRITE;
              r_mem_data <= wdata_i;
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_READ: begin
          if (r_we) begin
            r_mem_data <= w_merged;
            r_state    <= S_WRITE;
          end else begin
            r_rdata <= w_load_ext;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_WRITE: begin
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done     <= 1'b0;
          r_busy     <= 1'b0;
          r_misalign <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Gated by rst_i so a reset landing in the WRITE cycle cannot commit a
  // partial read-modify-write.
  assign mem_we_o   = (r_state == S_WRITE) & r_write_en & !rst_i;
  assign mem_addr_o = r_mem_addr;
  assign mem_data_o = r_mem_data;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign rdata_o    = r_rdata;
  assign misalign_o = r_misalign;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//   Directed bench for load_store_unit with a word-wide memory model
//   (combinational read, write on rising edge when mem_we_o is high).
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        we_i;
  logic [2:0]  funct3_i;
  logic [11:0] addr_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        misalign_o;
  logic        mem_we_o;
  logic [11:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;

  logic [31:0] mem [0:1023];
  int          we_count = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  load_store_unit #(
    .ADDR_WIDTH(12),
    .DATA_WIDTH(32)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .we_i       (we_i),
    .funct3_i   (funct3_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .rdata_o    (rdata_o),
    .misalign_o (misalign_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_data_i (mem_data_i)
  );

  assign mem_data_i = mem[mem_addr_o[11:2]];

  always @(posedge clk_i) begin
    if (mem_we_o) begin
      mem[mem_addr_o[11:2]] <= mem_data_o;
      we_count <= we_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Presents a request for one edge; returns in cycle T+1.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [11:0] a,
                       input logic [31:0] d);
    req_i    = 1'b1;
    we_i     = we;
    funct3_i = f3;
    addr_i   = a;
    wdata_i  = d;
    step();
    req_i = 1'b0;
  endtask

  // Starting in cycle T+1, waits (bounded) for done_o and checks its latency.
  task automatic wait_done(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      if (done_o) begin
        lat = c;
        break;
      end
      step();
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [11:0] a,
                         input int exp_lat, input logic [31:0] exp_rdata, input logic exp_mis);
    issue(1'b0, f3, a, 32'h0);
    wait_done(tag, exp_lat);
    chk({tag, " rdata"}, rdata_o, exp_rdata);
    chk({tag, " misalign"}, {31'b0, misalign_o}, {31'b0, exp_mis});
    step();
    $display("load  %s addr=0x%03h funct3=%03b rdata=0x%08h", tag, a, f3, rdata_o);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [11:0] a,
                          input logic [31:0] d, input int exp_lat);
    issue(1'b1, f3, a, d);
    wait_done(tag, exp_lat);
    step();
    $display("store %s addr=0x%03h funct3=%03b wdata=0x%08h", tag, a, f3, d);
  endtask

  logic [7:0] exp_busy;
  logic [7:0] exp_done;
  int         done_pulses;
  int         we_base;

  initial begin
    rst_i    = 1'b1;
    req_i    = 1'b0;
    we_i     = 1'b0;
    funct3_i = 3'b000;
    addr_i   = 12'h000;
    wdata_i  = 32'h0;
    step();
    step();

    // Reset state
    chk("rst busy",     {31'b0, busy_o},     32'h0);
    chk("rst done",     {31'b0, done_o},     32'h0);
    chk("rst rdata",    rdata_o,             32'h0);
    chk("rst misalign", {31'b0, misalign_o}, 32'h0);
    chk("rst mem_we",   {31'b0, mem_we_o},   32'h0);
    chk("rst mem_data", mem_data_o,          32'h0);
    $display("reset checked");
    rst_i = 1'b0;
    step();

    // 1. SW then LW
    issue(1'b1, 3'b010, 12'h010, 32'hDEADBEEF);
    chk("sw we T+1",   {31'b0, mem_we_o}, 32'h1);
    chk("sw addr T+1", {20'b0, mem_addr_o}, 32'h010);
    chk("sw data T+1", mem_data_o, 32'hDEADBEEF);
    chk("sw busy T+1", {31'b0, busy_o}, 32'h1);
    chk("sw done T+1", {31'b0, done_o}, 32'h0);
    step();
    chk("sw done T+2", {31'b0, done_o}, 32'h1);
    chk("sw we T+2",   {31'b0, mem_we_o}, 32'h0);
    chk("sw mem",      mem[4], 32'hDEADBEEF);
    step();
    chk("sw idle busy", {31'b0, busy_o}, 32'h0);
    $display("store SW addr=0x010 wdata=0xdeadbeef");
    do_load("LW", 3'b010, 12'h010, 2, 32'hDEADBEEF, 1'b0);

    // 2. SB read-modify-write, then LB / LBU
    issue(1'b1, 3'b000, 12'h013, 32'h000000A5);
    chk("sb we T+1", {31'b0, mem_we_o}, 32'h0);
    step();
    chk("sb we T+2",   {31'b0, mem_we_o}, 32'h1);
    chk("sb data T+2", mem_data_o, 32'hA5ADBEEF);
    chk("sb done T+2", {31'b0, done_o}, 32'h0);
    step();
    chk("sb done T+3", {31'b0, done_o}, 32'h1);
    chk("sb mem",      mem[4], 32'hA5ADBEEF);
    step();
    $display("store SB addr=0x013 wdata=0x000000a5");
    do_load("LB",  3'b000, 12'h013, 2, 32'hFFFFFFA5, 1'b0);
    do_load("LBU", 3'b100, 12'h013, 2, 32'h000000A5, 1'b0);

    // 3. SH, then LH / LHU on both halves
    do_store("SH", 3'b001, 12'h012, 32'h00001234, 3);
    chk("sh mem", mem[4], 32'h1234BEEF);
    do_load("LH hi", 3'b001, 12'h012, 2, 32'h00001234, 1'b0);
    do_load("LH lo", 3'b001, 12'h010, 2, 32'hFFFFBEEF, 1'b0);
    do_load("LHU",   3'b101, 12'h010, 2, 32'h0000BEEF, 1'b0);

    // Invalid funct3: store writes nothing, load returns 0, normal latency
    we_base = we_count;
    do_store("S inv", 3'b011, 12'h010, 32'hFFFFFFFF, 2);
    chk("inv store no we", 32'(we_count - we_base), 32'h0);
    chk("inv store mem",   mem[4], 32'h1234BEEF);
    do_load("L inv", 3'b110, 12'h010, 2, 32'h0, 1'b0);

    // 4. req_i held high across two loads
    exp_busy    = 8'b0001_1011;
    exp_done    = 8'b0001_0010;
    done_pulses = 0;
    req_i    = 1'b1;
    we_i     = 1'b0;
    funct3_i = 3'b010;
    addr_i   = 12'h010;
    step();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("hold busy c%0d", i + 1), {31'b0, busy_o}, {31'b0, exp_busy[i]});
      chk($sformatf("hold done c%0d", i + 1), {31'b0, done_o}, {31'b0, exp_done[i]});
      if (done_o) done_pulses++;
      if (i == 3) req_i = 1'b0;
      step();
    end
    chk("hold done pulses", 32'(done_pulses), 32'd2);
    chk("hold rdata", rdata_o, 32'h1234BEEF);
    $display("load  back-to-back LW x2 pulses=%0d", done_pulses);

    // 5. Reset during the WRITE cycle of SB
    we_base = we_count;
    issue(1'b1, 3'b000, 12'h010, 32'h00000011);
    step();
    chk("rmw we before rst", {31'b0, mem_we_o}, 32'h1);
    rst_i = 1'b1;
    #1;
    chk("rmw we under rst", {31'b0, mem_we_o}, 32'h0);
    step();
    chk("rmw rst busy",     {31'b0, busy_o},     32'h0);
    chk("rmw rst done",     {31'b0, done_o},     32'h0);
    chk("rmw rst rdata",    rdata_o,             32'h0);
    chk("rmw rst misalign", {31'b0, misalign_o}, 32'h0);
    chk("rmw rst mem_we",   {31'b0, mem_we_o},   32'h0);
    chk("rmw rst mem_addr", {20'b0, mem_addr_o}, 32'h0);
    chk("rmw rst mem_data", mem_data_o,          32'h0);
    chk("rmw mem unchanged", mem[4], 32'h1234BEEF);
    chk("rmw no write", 32'(we_count - we_base), 32'h0);
    rst_i = 1'b0;
    step();
    $display("store SB addr=0x010 aborted by reset");

    // 6. Misaligned LW
    we_base = we_count;
`ifdef MISALIGN_TRAP_EN
    do_load("LW mis", 3'b010, 12'h011, 1, 32'h0, 1'b1);
`else
    do_load("LW mis", 3'b010, 12'h011, 2, 32'h1234BEEF, 1'b0);
`endif
    chk("LW mis no we", 32'(we_count - we_base), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
